multicycle_controller: RTL

//  Main control FSM for the multicycle RV32 core. Sequences the shared ALU, register file, memory and PC through fetch/decode/execute/writeback.

---
 rtl/multicycle_controller.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32 core.
// Sequences fetch/decode/execute/writeback over the shared ALU, register
// file, memory and PC. The Moore outputs are decoded from the state register.
// Optional feature: define MULTICYCLE_MEM_READY_EN to make FETCH, MEMREAD
// and MEMWRITE wait for memReady.
// ILLEGAL_HALT=1 keeps ILLEGAL until reset. ILLEGAL_HALT=0 leaves ILLEGAL
// after one cycle and returns to FETCH, so the bad instruction is skipped.
module multicycle_controller #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       memReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       instrDone,
    output logic       illegalInstr,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t     state_r;
    state_t     next_state_s;
    state_t     out_state_s;
    logic       illegal_r;
    logic       mem_ready_s;

    logic       pc_update_s;
    logic       branch_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic       reg_write_s;
    logic       instr_done_s;

`ifdef MULTICYCLE_MEM_READY_EN
    assign mem_ready_s = memReady;
`else
    // Without the handshake every memory access completes in one cycle.
    logic unused_mem_ready_s;
    assign unused_mem_ready_s = memReady;
    assign mem_ready_s        = 1'b1;
`endif

    // State register and sticky illegal-instruction flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == S_ILLEGAL) begin
                illegal_r <= 1'b1;
            end
        end
    end

    // Next-state logic. op is looked at only in DECODE and MEMADR.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:    next_state_s = mem_ready_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_R:         next_state_s = S_EXECUTER;
                    OP_I:         next_state_s = S_EXECUTEI;
                    OP_JAL:       next_state_s = S_JAL;
                    OP_BEQ:       next_state_s = S_BEQ;
                    default:      next_state_s = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   next_state_s = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state_s = mem_ready_s ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: next_state_s = mem_ready_s ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: next_state_s = S_ALUWB;
            S_EXECUTEI: next_state_s = S_ALUWB;
            S_JAL:      next_state_s = S_ALUWB;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BEQ:      next_state_s = S_FETCH;
            S_ILLEGAL:  next_state_s = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Moore output decode. During reset the FETCH selects are shown,
    // whatever state the register still holds.
    always_comb begin
        out_state_s  = reset ? S_FETCH : state_r;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        reg_write_s  = 1'b0;
        instr_done_s = 1'b0;
        case (out_state_s)
            S_FETCH: begin
                ir_write_s   = mem_ready_s;
                pc_update_s  = mem_ready_s;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = mem_ready_s;
            end
            S_EXECUTER: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s  = 2'b10;
                alu_op_s     = 2'b01;
                branch_s     = 1'b1;
                instr_done_s = 1'b1;
            end
            default: begin
                pc_update_s = 1'b0;
            end
        endcase
    end

    // Write enables are forced low while reset is asserted.
    assign PCWrite      = ~reset & (pc_update_s | (branch_s & zero));
    assign IRWrite      = ~reset & ir_write_s;
    assign MemWrite     = ~reset & mem_write_s;
    assign RegWrite     = ~reset & reg_write_s;
    assign instrDone    = ~reset & instr_done_s;
    assign AdrSrc       = adr_src_s;
    assign ResultSrc    = result_src_s;
    assign ALUSrcA      = alu_src_a_s;
    assign ALUSrcB      = alu_src_b_s;
    assign ALUOp        = alu_op_s;
    assign illegalInstr = illegal_r;
    assign state        = state_r;

endmodule
